// File: rtl/riscv_v_pkg.sv
// Shared constants for the vector-unit pipeline blocks.
package riscv_v_pkg;

  localparam int unsigned RISCV_V_ELASTIC_MAX_STAGES = 8;

endpackage

// File: rtl/riscv_v_elastic_slot.sv
// One valid/data register pair of the elastic pipeline.
// adv is the advance term of the stage downstream (out_ready for the head).
module riscv_v_elastic_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              adv,
  input  logic              prev_v,
  input  logic [DATA_W-1:0] prev_d,
  output logic              v,
  output logic [DATA_W-1:0] d,
  output logic              adv_up
);

  // This slot can take a new item when it is empty or its occupant moves on.
  assign adv_up = adv | ~v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (adv_up) begin
      v <= prev_v;
      if (prev_v) begin
        d <= prev_d;
      end
    end
  end

endmodule

// File: rtl/riscv_v_elastic_stage.sv
// Valid/ready pipeline of NUM_STAGES registers with flush, backpressure and
// bubble collapsing; the consumer throttles the flow through out_ready.
module riscv_v_elastic_stage
  import riscv_v_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned OCC_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  if (NUM_STAGES < 1 || NUM_STAGES > RISCV_V_ELASTIC_MAX_STAGES) begin : g_bad_stages
    $error("riscv_v_elastic_stage: NUM_STAGES must be within 1..%0d", RISCV_V_ELASTIC_MAX_STAGES);
  end

  // Index 0 is the upstream input; index NUM_STAGES is the output register.
  logic [NUM_STAGES:0]   v_chain;
  logic [DATA_W-1:0]     d_chain [NUM_STAGES+1];
  logic [NUM_STAGES+1:1] adv_chain;

  assign v_chain[0]              = in_valid & ~flush;
  assign d_chain[0]              = in_data;
  assign adv_chain[NUM_STAGES+1] = out_ready;

  for (genvar i = 1; i <= NUM_STAGES; i++) begin : g_slot
    riscv_v_elastic_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .adv    (adv_chain[i+1]),
      .prev_v (v_chain[i-1]),
      .prev_d (d_chain[i-1]),
      .v      (v_chain[i]),
      .d      (d_chain[i]),
      .adv_up (adv_chain[i])
    );
  end

  // Combinational path from out_ready to in_ready is deliberate.
  assign in_ready  = adv_chain[1] & ~flush;
  assign out_valid = v_chain[NUM_STAGES];
  assign out_data  = d_chain[NUM_STAGES];

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 1; i <= NUM_STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v_chain[i]);
    end
  end

endmodule
